rect_fill_writer: RTL and testbench
===================================

Name: rect_fill_writer

Overview:
- Hardware rectangle-fill engine that drives the write port of the 160x120, 3-bit-colour image RAM.
- The VGA XY controller reads that RAM; this block writes it, replacing manual switch-and-key pixel pokes.
- On a start pulse it latches two corner points and a colour, then writes one pixel per clock in raster order.
- It pulses done when the whole rectangle has been written.

Parameters:
- WIDTH, 160, screen width in pixels.
- HEIGHT, 120, screen height in pixels.
- XW, 8, x coordinate width.
- YW, 7, y coordinate width.
- CW, 3, colour width.

Ports:
- CLOCK_50  in   1   system clock; the only clock in the block.
- reset     in   1   asynchronous, active-high reset.
- start     in   1   request pulse; sampled only in IDLE.
- x0        in   XW  corner A x.
- y0        in   YW  corner A y.
- x1        in   XW  corner B x.
- y1        in   YW  corner B y.
- color     in   CW  fill colour.
- busy      out  1   high while a fill is in progress.
- done      out  1   one-cycle pulse after the last write.
- we        out  1   RAM write enable.
- xw        out  XW  RAM write x.
- yw        out  YW  RAM write y.
- din       out  CW  RAM write data.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, we=0, xw=0, yw=0, din=0. Takes effect immediately, including mid-fill; no further writes are issued after reset.
- States: IDLE, FILL, DONE.
- IDLE -> FILL when start=1 at edge N. At that edge the block captures:
  - each coordinate clamped to WIDTH-1 / HEIGHT-1 first;
  - xl=min(x0c,x1c), xh=max(x0c,x1c), yl=min(y0c,y1c), yh=max(y0c,y1c);
  - colour into the din register.
- Clamping comes before min/max, so the rectangle is always non-empty (at least one pixel).
- FILL, cycle N+1 onward:
  - we=1, busy=1, din=captured colour.
  - First write is at (xl,yl).
  - Each cycle: if xw<xh then xw++; otherwise xw=xl and yw++.
  - At the edge where (xw,yw)=(xh,yh) is written, the next state is DONE.
- DONE (one cycle): we=0, busy=0, done=1; then IDLE.
- Pixel count P=(xh-xl+1)*(yh-yl+1). Last write is at cycle N+P; done is at cycle N+P+1.
- start is ignored in FILL and DONE. No queuing.
- Changes to x0/y0/x1/y1/color while busy have no effect on the fill in progress.
- IDLE outputs: we=0, done=0; xw/yw/din hold their last values.
- Arithmetic: all compares are unsigned. xw/yw never exceed WIDTH-1/HEIGHT-1. No wrap past the screen edge.
- A start on the reset-release edge is accepted normally.

Decomposition:
- Package vga_xy_pkg holds:
  - WIDTH, HEIGHT, XW, YW, CW;
  - state enum (IDLE, FILL, DONE);
  - colour constants (BLACK=0 ... WHITE=7), shared with the image RAM and the VGA controller.
- One sub-module, raster_counter:
  - loads xl/xh/yl/yh;
  - steps x/y with wrap;
  - outputs a last flag when (x,y)=(xh,yh).
- The FSM and clamp/min/max logic stay in rect_fill_writer.

Test Plan:
- Basic fill: reset, then start with (2,3)-(4,4), colour 5 -> exactly 6 writes in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), all with din=5 and we=1; done at N+7; busy high N+1..N+6.
- Swapped corners: (10,5)-(8,5), colour 2 -> writes (8,5),(9,5),(10,5); done at N+4.
- Clipping: (158,118)-(200,127), colour 7 -> writes (158,118),(159,118),(158,119),(159,119) only; xw never >159 and yw never >119.
- Single pixel: (0,0)-(0,0), colour 1 -> one write at N+1; done at N+2.
- Interference while busy: start a fill, then pulse start with new coordinates and change color during FILL -> extra start ignored, din constant, write sequence unchanged.
- Reset abort: full-screen fill (0,0)-(159,119); assert reset at write 500 -> we, busy and done drop to 0 asynchronously with no further writes. After release, a new (1,1)-(1,1) fill completes normally. An unaborted full screen gives done at N+19201.

Source files
------------

// File: rtl/vga_xy_pkg.sv
// vga_xy_pkg: screen geometry, fill FSM states and colour codes shared by the image RAM, VGA controller and fill engine.
package vga_xy_pkg;
  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;
  localparam int XW     = 8;
  localparam int YW     = 7;
  localparam int CW     = 3;
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  localparam logic [CW-1:0] BLACK   = 3'd0;
  localparam logic [CW-1:0] BLUE    = 3'd1;
  localparam logic [CW-1:0] GREEN   = 3'd2;
  localparam logic [CW-1:0] CYAN    = 3'd3;
  localparam logic [CW-1:0] RED     = 3'd4;
  localparam logic [CW-1:0] MAGENTA = 3'd5;
  localparam logic [CW-1:0] YELLOW  = 3'd6;
  localparam logic [CW-1:0] WHITE   = 3'd7;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: walks x across [xl,xh] then y across [yl,yh]; last flags the bottom-right corner.
module raster_counter
  import vga_xy_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] xl,
  input  logic [XW-1:0] xh,
  input  logic [YW-1:0] yl,
  input  logic [YW-1:0] yh,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);
  logic [XW-1:0] xl_r, xh_r;
  logic [YW-1:0] yh_r;
  assign last = (x == xh_r) && (y == yh_r);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      xl_r <= '0;
      xh_r <= '0;
      yh_r <= '0;
    end else if (load) begin
      x    <= xl;
      y    <= yl;
      xl_r <= xl;
      xh_r <= xh;
      yh_r <= yh;
    end else if (step) begin
      x <= (x < xh_r) ? x + XW'(1) : xl_r;
      y <= (x < xh_r) ? y : y + YW'(1);
    end
  end
endmodule

// File: rtl/rect_fill_writer.sv
// rect_fill_writer: on start, clamps and orders two corners, then writes one pixel per clock in raster order.
module rect_fill_writer
  import vga_xy_pkg::*;
(
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] color,
  output logic          busy,
  output logic          done,
  output logic          we,
  output logic [XW-1:0] xw,
  output logic [YW-1:0] yw,
  output logic [CW-1:0] din
);
  state_t state;
  logic [XW-1:0] x0c, x1c, xl, xh;
  logic [YW-1:0] y0c, y1c, yl, yh;
  logic load, step, last;
  // Clamp before ordering so the rectangle always holds at least one on-screen pixel
  always_comb begin
    x0c = (x0 > XMAX) ? XMAX : x0;
    x1c = (x1 > XMAX) ? XMAX : x1;
    y0c = (y0 > YMAX) ? YMAX : y0;
    y1c = (y1 > YMAX) ? YMAX : y1;
    xl  = (x0c < x1c) ? x0c : x1c;
    xh  = (x0c < x1c) ? x1c : x0c;
    yl  = (y0c < y1c) ? y0c : y1c;
    yh  = (y0c < y1c) ? y1c : y0c;
  end
  assign load = (state == IDLE) && start;
  assign step = (state == FILL) && !last;
  raster_counter u_cnt (
    .clk  (CLOCK_50),
    .rst  (reset),
    .load (load),
    .step (step),
    .xl   (xl),
    .xh   (xh),
    .yl   (yl),
    .yh   (yh),
    .x    (xw),
    .y    (yw),
    .last (last)
  );
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      we    <= 1'b0;
      din   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= FILL;
          busy  <= 1'b1;
          we    <= 1'b1;
          din   <= color;
        end
        FILL: if (last) begin
          state <= DONE;
          busy  <= 1'b0;
          we    <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rect_fill_writer.sv
// tb_rect_fill_writer: directed fills checked pixel by pixel against hand-computed rectangle bounds.
module tb_rect_fill_writer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x0 = '0, x1 = '0;
  logic [6:0] y0 = '0, y1 = '0;
  logic [2:0] color = '0;
  logic       busy, done, we;
  logic [7:0] xw;
  logic [6:0] yw;
  logic [2:0] din;
  int total = 0;
  int bad = 0;

  rect_fill_writer dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .x1       (x1),
    .y1       (y1),
    .color    (color),
    .busy     (busy),
    .done     (done),
    .we       (we),
    .xw       (xw),
    .yw       (yw),
    .din      (din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected bounds (exl..eyh) are supplied per test; pixel i is the i-th raster point inside them.
  task automatic fill(input logic [7:0] ax, input logic [6:0] ay, input logic [7:0] bx, input logic [6:0] by,
                      input logic [2:0] col, input logic [7:0] exl, input logic [7:0] exh,
                      input logic [6:0] eyl, input logic [6:0] eyh, input bit meddle, input int abort_at);
    int p;
    logic [7:0] ex;
    logic [6:0] ey;
    p  = (int'(exh) - int'(exl) + 1) * (int'(eyh) - int'(eyl) + 1);
    ex = exl;
    ey = eyl;
    @(negedge clk);
    x0 = ax; y0 = ay; x1 = bx; y1 = by; color = col; start = 1'b1;
    for (int i = 1; i <= p + 1; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i <= p) begin
        chk("we", 32'(we), 32'd1);
        chk("busy", 32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
        chk("xw", 32'(xw), 32'(ex));
        chk("yw", 32'(yw), 32'(ey));
        chk("din", 32'(din), 32'(col));
        if (ex < exh) ex = ex + 8'd1;
        else begin
          ex = exl;
          ey = ey + 7'd1;
        end
      end else begin
        chk("done", 32'(done), 32'd1);
        chk("we_done", 32'(we), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
      end
      if (meddle && i == 2) begin
        start = 1'b1; x0 = 8'd0; y0 = 7'd0; x1 = 8'd5; y1 = 7'd5; color = ~col;
      end
      if (abort_at == i) begin
        reset = 1'b1;
        #1;
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) begin
          @(negedge clk);
          chk("abort_quiet", 32'(we), 32'd0);
        end
        reset = 1'b0;
        return;
      end
    end
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_we", 32'(we), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("hold_xw", 32'(xw), 32'(exh));
    chk("hold_yw", 32'(yw), 32'(eyh));
    chk("hold_din", 32'(din), 32'(col));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_xw", 32'(xw), 32'd0);
    chk("rst_yw", 32'(yw), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    reset = 1'b0;
    fill(8'd2, 7'd3, 8'd4, 7'd4, 3'd5, 8'd2, 8'd4, 7'd3, 7'd4, 1'b0, 0);
    fill(8'd10, 7'd5, 8'd8, 7'd5, 3'd2, 8'd8, 8'd10, 7'd5, 7'd5, 1'b0, 0);
    fill(8'd158, 7'd118, 8'd200, 7'd127, 3'd7, 8'd158, 8'd159, 7'd118, 7'd119, 1'b0, 0);
    fill(8'd0, 7'd0, 8'd0, 7'd0, 3'd1, 8'd0, 8'd0, 7'd0, 7'd0, 1'b0, 0);
    fill(8'd22, 7'd31, 8'd20, 7'd30, 3'd6, 8'd20, 8'd22, 7'd30, 7'd31, 1'b1, 0);
    fill(8'd0, 7'd0, 8'd159, 7'd119, 3'd4, 8'd0, 8'd159, 7'd0, 7'd119, 1'b0, 500);
    chk("post_abort_xw", 32'(xw), 32'd0);
    chk("post_abort_din", 32'(din), 32'd0);
    fill(8'd1, 7'd1, 8'd1, 7'd1, 3'd7, 8'd1, 8'd1, 7'd1, 7'd1, 1'b0, 0);
    fill(8'd159, 7'd119, 8'd0, 7'd0, 3'd3, 8'd0, 8'd159, 7'd0, 7'd119, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
